// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the ram_ctrl block: widths, operation codes and the
// controller state encoding. RAM_CTRL_INIT_EN adds the power-up clearing state.
package ram_ctrl_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3
`ifdef RAM_CTRL_INIT_EN
        , ST_INIT = 3'd4
`endif
    } state_t;

`ifdef RAM_CTRL_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req[0] is requester A, req[1] is requester B.
// The grant is combinational and one-hot; the last-granted record moves only
// when the grant is accepted. Out of reset B counts as last served, so A wins
// the first contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_b_q;  // 1: B was granted most recently

    // Contention goes to whoever was not served last.
    always_comb begin
        gnt[0] = req[0] & (~req[1] | last_b_q);
        gnt[1] = req[1] & (~req[0] | ~last_b_q);
    end

    // Record the winner of each accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            last_b_q <= 1'b1;
        end else if (accept) begin
            last_b_q <= gnt[1];
        end
    end

endmodule

// File: rtl/ram_ctrl.sv
// Two-requester controller for an external 8x8 latch RAM. Each access runs
// IDLE -> SETUP -> STROBE -> HOLD with every output registered; ram_sel is
// high only during STROBE. Define RAM_CTRL_INIT_EN to add an INIT state that
// clears all eight locations after reset before any request is served.
module ram_ctrl
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_op,
    input  logic [2:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_rvalid,
    input  logic       b_req,
    input  logic       b_op,
    input  logic [2:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_rvalid,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [7:0] ram_inp,
    output logic [2:0] ram_addr,
    output logic       ram_op,
    output logic       ram_sel,
    input  logic [7:0] ram_outp
);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;   // 0: A owns the access, 1: B
    logic        op_d;
    logic [2:0]  addr_d;
    logic [7:0]  wdata_d;
    logic [7:0]  rdata_d;
    logic        a_gnt_d, b_gnt_d, a_rvalid_d, b_rvalid_d;
    logic        sel_d, busy_d;
    logic [1:0]  arb_gnt;
    logic        arb_accept;
`ifdef RAM_CTRL_INIT_EN
    logic        init_q, init_d;     // clearing sweep still in progress
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({b_req, a_req}),
        .accept (arb_accept),
        .gnt    (arb_gnt)
    );

    // Next-state and next-output logic; ram_op/addr/inp double as the latched request.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        owner_d    = owner_q;
        op_d       = ram_op;
        addr_d     = ram_addr;
        wdata_d    = ram_inp;
        rdata_d    = rdata;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        arb_accept = 1'b0;
`ifdef RAM_CTRL_INIT_EN
        init_d     = init_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    arb_accept = 1'b1;
                    owner_d    = arb_gnt[1];
                    a_gnt_d    = arb_gnt[0];
                    b_gnt_d    = arb_gnt[1];
                    op_d       = arb_gnt[1] ? b_op    : a_op;
                    addr_d     = arb_gnt[1] ? b_addr  : a_addr;
                    wdata_d    = arb_gnt[1] ? b_wdata : a_wdata;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
                if (ram_op == OP_READ) begin
                    rdata_d    = ram_outp;
                    a_rvalid_d = ~owner_q;
                    b_rvalid_d = owner_q;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
`ifdef RAM_CTRL_INIT_EN
                if (init_q) begin
                    if (ram_addr == LAST_ADDR) begin
                        init_d = 1'b0;
                    end else begin
                        addr_d  = ram_addr + 3'd1;
                        state_d = ST_SETUP;
                    end
                end
`endif
            end
`ifdef RAM_CTRL_INIT_EN
            ST_INIT: begin
                op_d    = OP_WRITE;
                addr_d  = '0;
                wdata_d = '0;
                state_d = ST_SETUP;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sel_d  = (state_d == ST_STROBE);
        busy_d = (state_d != ST_IDLE);
    end

    // Register state and all outputs; reset aborts any access, dropping ram_sel at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RESET_STATE;
            owner_q  <= 1'b0;
            ram_op   <= 1'b0;
            ram_addr <= '0;
            ram_inp  <= '0;
            rdata    <= '0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            ram_sel  <= 1'b0;
            busy     <= 1'b0;
`ifdef RAM_CTRL_INIT_EN
            init_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ram_op   <= op_d;
            ram_addr <= addr_d;
            ram_inp  <= wdata_d;
            rdata    <= rdata_d;
            a_gnt    <= a_gnt_d;
            b_gnt    <= b_gnt_d;
            a_rvalid <= a_rvalid_d;
            b_rvalid <= b_rvalid_d;
            ram_sel  <= sel_d;
            busy     <= busy_d;
`ifdef RAM_CTRL_INIT_EN
            init_q   <= init_d;
`endif
        end
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameters: none; address width fixed at 3, data width fixed at 8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_req  input  1  requester A access request; held until a_gnt.
REQ-005 a_op  input  1  requester A operation, 1=write, 0=read.
REQ-006 a_addr  input  3  requester A byte address.
REQ-007 a_wdata  input  8  requester A write data.
REQ-008 a_gnt  output  1  one-cycle pulse: A request accepted.
REQ-009 a_rvalid  output  1  one-cycle pulse: rdata holds A read result.
REQ-010 b_req, b_op, b_addr, b_wdata, b_gnt, b_rvalid: same widths and meaning for requester B.
REQ-011 rdata  output  8  read data shared by both requesters.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 ram_inp  output  8, ram_addr  output  3, ram_op  output  1, ram_sel  output  1: drive the 8x8 latch RAM.
REQ-014 ram_outp  input  8  RAM read data.

Function
REQ-015 FSM states: INIT, IDLE, SETUP, STROBE, HOLD; all outputs registered.
REQ-016 IDLE: no request -> stay IDLE; one request -> grant it; both -> grant the requester not granted last (round-robin).
REQ-017 On the grant edge, latch op/addr/wdata of the winner, go to SETUP; the winner's gnt is high for exactly the SETUP cycle.
REQ-018 SETUP: ram_addr/ram_op/ram_inp driven from latched values, ram_sel=0.
REQ-019 STROBE: same values, ram_sel=1 for exactly one cycle.
REQ-020 HOLD: ram_sel=0, addr/op/inp held stable; next state IDLE.
REQ-021 Read: ram_outp captured into rdata on the edge ending STROBE; the owner's rvalid is high during HOLD; rdata holds until the next read capture.
REQ-022 Write: no rvalid pulse; rdata unchanged.
REQ-023 Latency: request seen in IDLE at edge T -> gnt in cycle T+1, strobe in T+2, rvalid in T+3, IDLE in T+4; one access per 4 cycles maximum.
REQ-024 Requests arriving while busy are ignored until IDLE; a req held continuously by one requester with the other idle is granted back-to-back.
REQ-025 ram_sel is never high in IDLE, SETUP, HOLD or INIT except as stated in REQ-029.

Reset
REQ-026 rst_n low: state -> IDLE (INIT when RAM_CTRL_INIT_EN is defined); all outputs 0; round-robin favours A first.
REQ-027 Reset asserted mid-access aborts it: ram_sel drops asynchronously, no gnt or rvalid is produced, and the RAM content at that address is undefined.

Configuration
REQ-028 Macro RAM_CTRL_INIT_EN selects power-up clearing.
REQ-029 Defined: after reset, INIT writes 0x00 to addresses 0..7 in order using the SETUP/STROBE/HOLD sequence (24 cycles); busy=1 throughout; requests wait; then IDLE.
REQ-030 Undefined: INIT state is absent; reset goes straight to IDLE and RAM content is undefined.

Structure
REQ-031 Shared package: FSM state encoding, OP_WRITE/OP_READ constants, width constants (3, 8).
REQ-032 The round-robin arbiter is one sub-module, rr_arb2 (req[1:0], last-grant state, one-hot grant).
REQ-033 The 8x8 RAM is instantiated outside the block; the block has no storage apart from its latched request and rdata.

Verification
REQ-034 A write addr 5 data 0xA5, then A read addr 5 -> a_gnt pulses in cycles T+1 and T+5, a_rvalid in T+7 with rdata=0xA5.
REQ-035 A and B request in the same cycle after reset -> A granted first, B granted 4 cycles later; again both -> B first, then A.
REQ-036 B read addr 2 with A idle -> ram_sel high in exactly one cycle, ram_addr=2 stable from SETUP through HOLD, b_rvalid only; a_rvalid stays 0.
REQ-037 rst_n pulled low during STROBE -> ram_sel=0 immediately, all outputs 0, no rvalid; normal grant after release.
REQ-038 RAM_CTRL_INIT_EN defined: busy=1 for 24 cycles after reset, eight strobes to addresses 0..7 with ram_inp=0x00, then a read of any address returns 0x00.
